led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
// PURPOSE
//   Parametrised LED pattern sequencer: successor to the fixed 2-LED flowing light.
//   Drives LED_NUM outputs, one pattern step every step period. Patterns: rotate
//   left, rotate right, ping-pong bounce, all-blink.
//   Run/pause and 4 speed grades are selectable at run time. Sits directly on the
//   board LED pins; controls come from keys/switches already debounced upstream.
// PARAMETERS
//   LED_NUM      4           number of LEDs, legal range 2..32
//   TICK_CYCLES  25_000_000  sys_clk cycles per step at speed_sel=0; must be >= 8
//   CNT_W        25          prescaler width; must satisfy 2**CNT_W >= TICK_CYCLES
// PORTS
//   sys_clk     in   1        system clock, all logic on rising edge
//   sys_rst     in   1        asynchronous reset, active-high
//   en          in   1        1 = run, 0 = pause (prescaler and pattern frozen)
//   mode        in   2        00 rot-left, 01 rot-right, 10 ping-pong, 11 blink-all
//   speed_sel   in   2        step period = TICK_CYCLES >> speed_sel (x1,x2,x4,x8 speed)
//   led         out  LED_NUM  LED drive, 1 = lit, registered
//   step_pulse  out  1        1-cycle strobe, high in the cycle led takes a new value
// BEHAVIOUR
//   Reset (async assert, sync release): cnt=0, led=1 (bit0 lit), dir=left,
//     mode_q=00, step_pulse=0. Reset mid-operation aborts immediately to these values.
//   Prescaler: limit = TICK_CYCLES >> speed_sel. en=1: if cnt >= limit-1 then
//     cnt<=0 and step fires, else cnt<=cnt+1. en=0: cnt, led, dir hold; step_pulse=0.
//   Using >= (not ==): lowering the limit while cnt is above it fires a step on the
//     next enabled edge; no wrap through 2**CNT_W.
//   Step latency: led changes on the same edge cnt returns to 0; step_pulse is a
//     registered copy of the step condition, so it is high while new led is visible.
//   Mode sampling: mode is used only on a step edge. mode_q holds the last applied mode.
//     mode != mode_q at step: led loads start pattern, mode_q<=mode, no shift that step.
//     Start patterns: 00 -> bit0; 01 -> bit LED_NUM-1; 10 -> bit0, dir=left;
//     11 -> all ones.
//   mode == mode_q at step:
//     00: led <= {led[LED_NUM-2:0], led[LED_NUM-1]}  (bit i -> i+1, MSB wraps to bit0)
//     01: led <= {led[0], led[LED_NUM-1:1]}          (LSB wraps to MSB)
//     10: dir=left: shift left; if the new lit bit is LED_NUM-1, dir<=right.
//         dir=right: shift right; if the new lit bit is 0, dir<=left.
//         End LEDs are lit for one step each, no wrap.
//     11: led <= ~led (all on / all off alternate).
//   Recovery: in modes 00/01/10, a led value not one-hot (e.g. corruption) is
//     replaced by the mode start pattern at the next step.
//   en and mode changing on the same step edge: en=0 wins; nothing is applied.
//     The mode change takes effect at the first step after en returns to 1.
//   speed_sel change mid-period: cnt is not cleared; the new limit applies from
//     the next edge.
// TESTING  (LED_NUM=4, TICK_CYCLES=8 unless noted)
//   1 Reset, en=1, mode=00, speed=0 -> led 0001,0010,0100,1000,0001 every 8 clks.
//     step_pulse is 1 clk wide each time.
//   2 mode=10 from reset -> 0001,0010,0100,1000,0100,0010,0001,0010. Direction turns
//     exactly at the ends.
//   3 At led=0100, switch mode to 01 -> next step loads 1000, following steps
//     give 0100,0010,0001,1000.
//   4 mode=11 -> 1111 at first step, then 0000,1111 alternating. Returning to 00
//     -> next step loads 0001.
//   5 speed_sel=3 -> step every 1 clk. Set speed_sel 0->2 when cnt=5 -> step on next
//     edge, then every 2 clks.
//   6 en=0 for 20 clks mid-period -> led/cnt frozen, no step_pulse. Resume -> step
//     after the remaining count. Assert sys_rst mid-period -> led=0001 and cnt=0
//     immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern sequencer: rotate-left/right, ping-pong and blink-all patterns
// stepped by a run-time selectable prescaler, with run/pause control.
module led_pattern_gen #(
  parameter int LED_NUM     = 4,
  parameter int TICK_CYCLES = 25_000_000,
  parameter int CNT_W       = 25
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed_sel,
  output logic [LED_NUM-1:0] led,
  output logic               step_pulse
);

  typedef enum logic [1:0] {M_ROTL = 2'b00, M_ROTR = 2'b01, M_PING = 2'b10, M_BLINK = 2'b11} mode_e;
  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_e;

  localparam logic [CNT_W-1:0]   TICK    = CNT_W'(TICK_CYCLES);
  localparam logic [LED_NUM-1:0] LED_LSB = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] LED_MSB = LED_NUM'(1) << (LED_NUM - 1);

  logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
  logic [LED_NUM-1:0] r_led,    w_led_nxt;
  dir_e               r_dir,    w_dir_nxt;
  mode_e              r_mode_q, w_mode_nxt;
  logic               r_step;

  logic [CNT_W-1:0]   w_limit_m1;
  logic               w_step;
  logic               w_onehot;
  logic               w_go_left;
  logic [LED_NUM-1:0] w_shl, w_shr;
  mode_e              w_mode;

  assign w_mode     = mode_e'(mode);
  assign w_limit_m1 = (TICK >> speed_sel) - CNT_W'(1);
  // >= rather than == so a speed increase never lets cnt run past the new limit
  assign w_step     = en && (r_cnt >= w_limit_m1);
  assign w_onehot   = (r_led != '0) && ((r_led & (r_led - LED_LSB)) == '0);
  assign w_shl      = r_led << 1;
  assign w_shr      = r_led >> 1;
  // bounce off either end even if dir disagrees with the lit position
  assign w_go_left  = ((r_dir == DIR_LEFT) && !r_led[LED_NUM-1]) || r_led[0];

  function automatic logic [LED_NUM-1:0] start_pat(input mode_e m);
    case (m)
      M_ROTR:  start_pat = LED_MSB;
      M_BLINK: start_pat = '1;
      default: start_pat = LED_LSB;
    endcase
  endfunction

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_led_nxt  = r_led;
    w_dir_nxt  = r_dir;
    w_mode_nxt = r_mode_q;
    if (en) w_cnt_nxt = w_step ? '0 : r_cnt + CNT_W'(1);
    if (w_step) begin
      if (w_mode != r_mode_q || (w_mode != M_BLINK && !w_onehot)) begin
        w_mode_nxt = w_mode;
        w_led_nxt  = start_pat(w_mode);
        if (w_mode == M_PING) w_dir_nxt = DIR_LEFT;
      end else begin
        case (r_mode_q)
          M_ROTL:  w_led_nxt = {r_led[LED_NUM-2:0], r_led[LED_NUM-1]};
          M_ROTR:  w_led_nxt = {r_led[0], r_led[LED_NUM-1:1]};
          M_PING: begin
            if (w_go_left) begin
              w_led_nxt = w_shl;
              w_dir_nxt = w_shl[LED_NUM-1] ? DIR_RIGHT : DIR_LEFT;
            end else begin
              w_led_nxt = w_shr;
              w_dir_nxt = w_shr[0] ? DIR_LEFT : DIR_RIGHT;
            end
          end
          default: w_led_nxt = ~r_led;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt    <= '0;
      r_led    <= LED_LSB;
      r_dir    <= DIR_LEFT;
      r_mode_q <= M_ROTL;
      r_step   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_led    <= w_led_nxt;
      r_dir    <= w_dir_nxt;
      r_mode_q <= w_mode_nxt;
      r_step   <= w_step;
    end
  end

  assign led        = r_led;
  assign step_pulse = r_step;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus randomized control traffic
// compared every cycle against a position/direction reference model.
module tb_led_pattern_gen;

  localparam int N  = 4;
  localparam int T  = 8;
  localparam int CW = 4;

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [1:0]   speed_sel = 2'b00;
  logic [N-1:0] led;
  logic         step_pulse;

  int n_chk  = 0;
  int n_pass = 0;

  // reference state: lit position, travel direction, blink phase
  int m_cnt, m_pos, m_dir, m_mode_q;
  bit m_blink, m_step;

  led_pattern_gen #(.LED_NUM(N), .TICK_CYCLES(T), .CNT_W(CW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .mode(mode),
    .speed_sel(speed_sel), .led(led), .step_pulse(step_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic m_reset();
    m_cnt = 0; m_pos = 0; m_dir = 1; m_mode_q = 0; m_blink = 1'b0; m_step = 1'b0;
  endtask

  function automatic logic [N-1:0] m_led();
    logic [N-1:0] one;
    one = N'(1);
    if (m_mode_q == 3) return m_blink ? '1 : '0;
    return one << m_pos;
  endfunction

  task automatic m_clock();
    int lim;
    lim = T >> speed_sel;
    m_step = 1'b0;
    if (!en) return;
    if (m_cnt >= lim - 1) begin m_cnt = 0; m_step = 1'b1; end
    else m_cnt++;
    if (!m_step) return;
    if (int'(mode) != m_mode_q) begin
      m_mode_q = int'(mode);
      case (m_mode_q)
        0: m_pos = 0;
        1: m_pos = N - 1;
        2: begin m_pos = 0; m_dir = 1; end
        default: m_blink = 1'b1;
      endcase
    end else begin
      case (m_mode_q)
        0: m_pos = (m_pos + 1) % N;
        1: m_pos = (m_pos + N - 1) % N;
        2: begin
          m_pos += m_dir;
          if (m_pos == N - 1) m_dir = -1;
          else if (m_pos == 0) m_dir = 1;
        end
        default: m_blink = !m_blink;
      endcase
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge sys_clk);
    m_clock();
    #1;
    chk({tag, ".led"}, 32'(led), 32'(m_led()));
    chk({tag, ".stp"}, 32'(step_pulse), 32'(m_step));
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    m_reset();
    #12;
    chk("rst.led", 32'(led), 32'h1);
    chk("rst.stp", 32'(step_pulse), 32'h0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // rotate left for two full laps
    en = 1'b1; mode = 2'b00; speed_sel = 2'b00;
    run("rotl", 8 * 9);

    // ping-pong, then switch to rotate-right mid-run
    mode = 2'b10;
    run("ping", 8 * 10);
    mode = 2'b01;
    run("rotr", 8 * 6);

    // blink then back to rotate-left
    mode = 2'b11;
    run("blink", 8 * 4);
    mode = 2'b00;
    run("back", 8 * 2);

    // fastest speed, then speed change mid-period
    speed_sel = 2'b11;
    run("fast", 10);
    speed_sel = 2'b00;
    run("slow", 13);
    speed_sel = 2'b10;
    run("mid", 9);

    // pause with a mode change pending, then resume
    speed_sel = 2'b00;
    run("pre", 3);
    en = 1'b0; mode = 2'b10;
    run("pause", 20);
    en = 1'b1;
    run("resume", 20);

    // async reset mid-period: visible before any clock edge
    @(posedge sys_clk);
    m_clock();
    #2;
    sys_rst = 1'b1;
    #1;
    m_reset();
    chk("arst.led", 32'(led), 32'h1);
    chk("arst.stp", 32'(step_pulse), 32'h0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    mode = 2'b00;
    run("postrst", 16);

    // randomized control traffic
    for (int blk = 0; blk < 120; blk++) begin
      mode      = 2'($urandom_range(0, 3));
      speed_sel = 2'($urandom_range(0, 3));
      en        = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < int'($urandom_range(4, 60)); c++) begin
        if ($urandom_range(0, 15) == 0) en = ~en;
        if ($urandom_range(0, 31) == 0) speed_sel = 2'($urandom);
        cycle("rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
